// File: rtl/tl_pkg.sv
// TileLink-UL constants, default-width channel bundles
// and the A-channel beat-count helper.
package tl_pkg;

  localparam logic [2:0] TL_PUT_FULL    = 3'd0;
  localparam logic [2:0] TL_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] TL_ARITH       = 3'd2;
  localparam logic [2:0] TL_LOGICAL     = 3'd3;
  localparam logic [2:0] TL_GET         = 3'd4;
  localparam logic [2:0] TL_INTENT      = 3'd5;
  localparam logic [2:0] TL_ACK         = 3'd0;
  localparam logic [2:0] TL_ACK_DATA    = 3'd1;

  localparam int TL_SINK_W   = 1;
  localparam int TL_DPARAM_W = 2;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  param;
    logic [3:0]  size;
    logic [5:0]  source;
    logic [32:0] address;
    logic [7:0]  mask;
    logic [63:0] data;
  } a_chan_t;

  typedef struct packed {
    logic [2:0]             opcode;
    logic [TL_DPARAM_W-1:0] param;
    logic [3:0]             size;
    logic [5:0]             source;
    logic [TL_SINK_W-1:0]   sink;
    logic                   denied;
    logic [63:0]            data;
    logic                   corrupt;
  } d_chan_t;

  // Puts carry data on A, so they span 2^size bytes of beats.
  function automatic logic [31:0] beats(
    input logic [7:0]  size,
    input logic [2:0]  opcode,
    input int unsigned data_w
  );
    logic [31:0] n;
    n = 32'd1;
    if (!opcode[2]) begin
      n = (32'd1 << size) / (data_w / 8);
      if (n == 32'd0) n = 32'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/tl_xbar_n_to_1_rr_arbiter.sv
// N-way round-robin arbiter with a grant lock
// used to hold a burst or a stalled request.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic             lock,
  input  logic             load,
  input  logic             advance,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] held_q;
  logic [IDX_W-1:0] pick;
  logic             any;

  always_comb begin
    int j;
    pick = ptr_q;
    any  = 1'b0;
    j    = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr_q) + i;
      if (j >= N) j -= N;
      if (!any && req[j]) begin
        any  = 1'b1;
        pick = j[IDX_W-1:0];
      end
    end
  end

  assign gnt_idx = lock ? held_q : pick;
  assign gnt     = (lock || any) ? (N'(1) << gnt_idx) : '0;

  always_ff @(posedge clock) begin
    if (!reset) begin
      ptr_q  <= '0;
      held_q <= '0;
    end else begin
      if (load) held_q <= gnt_idx;
      if (advance) begin
        if (int'(gnt_idx) == N - 1) ptr_q <= '0;
        else ptr_q <= gnt_idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/tl_xbar_n_to_1.sv
// N-to-1 TileLink-UL crossbar: round-robin A mux with
// burst lock, D responses routed back by source prefix.
module tl_xbar_n_to_1
  import tl_pkg::*;
#(
  parameter int N_IN   = 4,
  parameter int SRC_W  = 4,
  parameter int ADDR_W = 33,
  parameter int DATA_W = 64,
  parameter int SIZE_W = 4,
  localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [N_IN-1:0]              in_a_valid,
  output logic [N_IN-1:0]              in_a_ready,
  input  logic [N_IN*3-1:0]            in_a_opcode,
  input  logic [N_IN*3-1:0]            in_a_param,
  input  logic [N_IN*SIZE_W-1:0]       in_a_size,
  input  logic [N_IN*SRC_W-1:0]        in_a_source,
  input  logic [N_IN*ADDR_W-1:0]       in_a_address,
  input  logic [N_IN*(DATA_W/8)-1:0]   in_a_mask,
  input  logic [N_IN*DATA_W-1:0]       in_a_data,
  output logic [N_IN-1:0]              in_d_valid,
  input  logic [N_IN-1:0]              in_d_ready,
  output logic [2:0]                   in_d_opcode,
  output logic [TL_DPARAM_W-1:0]       in_d_param,
  output logic [SIZE_W-1:0]            in_d_size,
  output logic [SRC_W-1:0]             in_d_source,
  output logic [TL_SINK_W-1:0]         in_d_sink,
  output logic                         in_d_denied,
  output logic [DATA_W-1:0]            in_d_data,
  output logic                         in_d_corrupt,
  output logic                         out_a_valid,
  input  logic                         out_a_ready,
  output logic [2:0]                   out_a_opcode,
  output logic [2:0]                   out_a_param,
  output logic [SIZE_W-1:0]            out_a_size,
  output logic [SRC_W+IDX_W-1:0]       out_a_source,
  output logic [ADDR_W-1:0]            out_a_address,
  output logic [DATA_W/8-1:0]          out_a_mask,
  output logic [DATA_W-1:0]            out_a_data,
  input  logic                         out_d_valid,
  output logic                         out_d_ready,
  input  logic [2:0]                   out_d_opcode,
  input  logic [TL_DPARAM_W-1:0]       out_d_param,
  input  logic [SIZE_W-1:0]            out_d_size,
  input  logic [SRC_W+IDX_W-1:0]       out_d_source,
  input  logic [TL_SINK_W-1:0]         out_d_sink,
  input  logic                         out_d_denied,
  input  logic [DATA_W-1:0]            out_d_data,
  input  logic                         out_d_corrupt,
  output logic                         err_unmapped
);

  localparam int MASK_W = DATA_W / 8;

  logic [31:0]      beats_left;
  logic [31:0]      beats_n;
  logic             idle;
  logic             stall_q;
  logic             a_fire;
  logic [N_IN-1:0]  gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] d_idx;
  int               sel;

  assign idle = (beats_left == 32'd0);
  assign sel  = int'(gnt_idx);

  rr_arbiter #(
    .N     (N_IN),
    .IDX_W (IDX_W)
  ) u_arb (
    .clock   (clock),
    .reset   (reset),
    .req     (in_a_valid),
    .lock    (!idle || stall_q),
    .load    (out_a_valid),
    .advance (a_fire && idle),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign out_a_valid   = reset && in_a_valid[gnt_idx];
  assign in_a_ready    = reset ? (gnt & {N_IN{out_a_ready}}) : '0;
  assign a_fire        = out_a_valid && out_a_ready;
  assign out_a_opcode  = in_a_opcode[sel*3 +: 3];
  assign out_a_param   = in_a_param[sel*3 +: 3];
  assign out_a_size    = in_a_size[sel*SIZE_W +: SIZE_W];
  assign out_a_source  = {gnt_idx, in_a_source[sel*SRC_W +: SRC_W]};
  assign out_a_address = in_a_address[sel*ADDR_W +: ADDR_W];
  assign out_a_mask    = in_a_mask[sel*MASK_W +: MASK_W];
  assign out_a_data    = in_a_data[sel*DATA_W +: DATA_W];

  assign beats_n = beats(8'(out_a_size), out_a_opcode, unsigned'(DATA_W));

  // A stalled first beat locks the grant so late requesters can't steal it.
  always_ff @(posedge clock) begin
    if (!reset) begin
      beats_left   <= '0;
      stall_q      <= 1'b0;
      err_unmapped <= 1'b0;
    end else begin
      if (a_fire) begin
        if (idle) beats_left <= beats_n - 32'd1;
        else beats_left <= beats_left - 32'd1;
      end
      stall_q <= out_a_valid && !out_a_ready;
      if (out_d_valid && int'(d_idx) >= N_IN) err_unmapped <= 1'b1;
    end
  end

  assign d_idx = out_d_source[SRC_W+IDX_W-1:SRC_W];

  // Responses to a non-existent input are accepted and dropped.
  always_comb begin
    in_d_valid  = '0;
    out_d_ready = 1'b0;
    if (reset) begin
      out_d_ready = 1'b1;
      for (int i = 0; i < N_IN; i++) begin
        if (int'(d_idx) == i) begin
          in_d_valid[i] = out_d_valid;
          out_d_ready   = in_d_ready[i];
        end
      end
    end
  end

  assign in_d_opcode  = out_d_opcode;
  assign in_d_param   = out_d_param;
  assign in_d_size    = out_d_size;
  assign in_d_source  = out_d_source[SRC_W-1:0];
  assign in_d_sink    = out_d_sink;
  assign in_d_denied  = out_d_denied;
  assign in_d_data    = out_d_data;
  assign in_d_corrupt = out_d_corrupt;

`ifndef SYNTHESIS
  always_ff @(posedge clock) begin
    if (reset) begin
      assert (gnt == '0 || $onehot(gnt));
      assert (!out_a_valid || gnt[gnt_idx]);
    end
  end
`endif

endmodule

// File: tb/tb_tl_xbar_n_to_1.sv
// Directed bench for tl_xbar_n_to_1: arbitration, bursts,
// stalls, D routing, unmapped responses and reset.
module tb_tl_xbar_n_to_1;

  localparam int N  = 4;
  localparam int SW = 4;
  localparam int AW = 33;
  localparam int DW = 64;
  localparam int ZW = 4;
  localparam int MW = 8;
  localparam int OW = 6;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic [N-1:0]    in_a_valid, in_a_ready;
  logic [N*3-1:0]  in_a_opcode, in_a_param;
  logic [N*ZW-1:0] in_a_size;
  logic [N*SW-1:0] in_a_source;
  logic [N*AW-1:0] in_a_address;
  logic [N*MW-1:0] in_a_mask;
  logic [N*DW-1:0] in_a_data;
  logic [N-1:0]    in_d_valid, in_d_ready;
  logic [2:0]      in_d_opcode;
  logic [1:0]      in_d_param;
  logic [ZW-1:0]   in_d_size;
  logic [SW-1:0]   in_d_source;
  logic            in_d_sink, in_d_denied, in_d_corrupt;
  logic [DW-1:0]   in_d_data;
  logic            out_a_valid, out_a_ready;
  logic [2:0]      out_a_opcode, out_a_param;
  logic [ZW-1:0]   out_a_size;
  logic [OW-1:0]   out_a_source;
  logic [AW-1:0]   out_a_address;
  logic [MW-1:0]   out_a_mask;
  logic [DW-1:0]   out_a_data;
  logic            out_d_valid, out_d_ready;
  logic [2:0]      out_d_opcode;
  logic [1:0]      out_d_param;
  logic [ZW-1:0]   out_d_size;
  logic [OW-1:0]   out_d_source;
  logic            out_d_sink, out_d_denied, out_d_corrupt;
  logic [DW-1:0]   out_d_data;
  logic            err_unmapped;

  // three-input instance for the unmapped-response case
  logic [2:0]    a3_ready, d3_valid, d3_ready_in;
  logic [2:0]    d3_opcode, o3_opcode, o3_param;
  logic [1:0]    d3_param;
  logic [ZW-1:0] d3_size, o3_size;
  logic [SW-1:0] d3_source;
  logic          d3_sink, d3_denied, d3_corrupt;
  logic [DW-1:0] d3_data, o3_data;
  logic          o3_valid, o3_d_ready, o3_d_valid, err3;
  logic [OW-1:0] o3_source, o3_d_source;
  logic [AW-1:0] o3_address;
  logic [MW-1:0] o3_mask;

  tl_xbar_n_to_1 dut (
    .clock(clock), .reset(reset),
    .in_a_valid(in_a_valid), .in_a_ready(in_a_ready),
    .in_a_opcode(in_a_opcode), .in_a_param(in_a_param),
    .in_a_size(in_a_size), .in_a_source(in_a_source),
    .in_a_address(in_a_address), .in_a_mask(in_a_mask),
    .in_a_data(in_a_data),
    .in_d_valid(in_d_valid), .in_d_ready(in_d_ready),
    .in_d_opcode(in_d_opcode), .in_d_param(in_d_param),
    .in_d_size(in_d_size), .in_d_source(in_d_source),
    .in_d_sink(in_d_sink), .in_d_denied(in_d_denied),
    .in_d_data(in_d_data), .in_d_corrupt(in_d_corrupt),
    .out_a_valid(out_a_valid), .out_a_ready(out_a_ready),
    .out_a_opcode(out_a_opcode), .out_a_param(out_a_param),
    .out_a_size(out_a_size), .out_a_source(out_a_source),
    .out_a_address(out_a_address), .out_a_mask(out_a_mask),
    .out_a_data(out_a_data),
    .out_d_valid(out_d_valid), .out_d_ready(out_d_ready),
    .out_d_opcode(out_d_opcode), .out_d_param(out_d_param),
    .out_d_size(out_d_size), .out_d_source(out_d_source),
    .out_d_sink(out_d_sink), .out_d_denied(out_d_denied),
    .out_d_data(out_d_data), .out_d_corrupt(out_d_corrupt),
    .err_unmapped(err_unmapped)
  );

  tl_xbar_n_to_1 #(.N_IN(3)) dut3 (
    .clock(clock), .reset(reset),
    .in_a_valid(3'b000), .in_a_ready(a3_ready),
    .in_a_opcode('0), .in_a_param('0),
    .in_a_size('0), .in_a_source('0),
    .in_a_address('0), .in_a_mask('0),
    .in_a_data('0),
    .in_d_valid(d3_valid), .in_d_ready(d3_ready_in),
    .in_d_opcode(d3_opcode), .in_d_param(d3_param),
    .in_d_size(d3_size), .in_d_source(d3_source),
    .in_d_sink(d3_sink), .in_d_denied(d3_denied),
    .in_d_data(d3_data), .in_d_corrupt(d3_corrupt),
    .out_a_valid(o3_valid), .out_a_ready(1'b0),
    .out_a_opcode(o3_opcode), .out_a_param(o3_param),
    .out_a_size(o3_size), .out_a_source(o3_source),
    .out_a_address(o3_address), .out_a_mask(o3_mask),
    .out_a_data(o3_data),
    .out_d_valid(o3_d_valid), .out_d_ready(o3_d_ready),
    .out_d_opcode(3'd0), .out_d_param(2'd0),
    .out_d_size('0), .out_d_source(o3_d_source),
    .out_d_sink(1'b0), .out_d_denied(1'b0),
    .out_d_data('0), .out_d_corrupt(1'b0),
    .err_unmapped(err3)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_a(input int i, input logic [2:0] op,
                       input logic [3:0] sz, input logic [3:0] src,
                       input logic [32:0] adr);
    in_a_opcode[i*3 +: 3]   = op;
    in_a_size[i*ZW +: ZW]   = sz;
    in_a_source[i*SW +: SW] = src;
    in_a_address[i*AW +: AW] = adr;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    in_a_valid = '0; in_a_opcode = '0; in_a_param = '0;
    in_a_size = '0; in_a_source = '0; in_a_address = '0;
    in_a_mask = '1; in_a_data = '0; in_d_ready = '0;
    out_a_ready = 1'b0; out_d_valid = 1'b0; out_d_opcode = 3'd1;
    out_d_param = '0; out_d_size = 4'd3; out_d_source = '0;
    out_d_sink = 1'b0; out_d_denied = 1'b0; out_d_data = '0;
    out_d_corrupt = 1'b0;
    o3_d_valid = 1'b0; o3_d_source = '0; d3_ready_in = '0;

    // reset with every request and response line active
    for (int i = 0; i < N; i++)
      set_a(i, 3'd4, 4'd3, 4'(8 + i), 33'(i * 256));
    in_a_valid = 4'hF; out_a_ready = 1'b1;
    out_d_valid = 1'b1; out_d_source = 6'h25; in_d_ready = 4'hF;
    step(); step();
    check("rst_out_a_valid", out_a_valid, 0);
    check("rst_in_a_ready", in_a_ready, 0);
    check("rst_in_d_valid", in_d_valid, 0);
    check("rst_out_d_ready", out_d_ready, 0);
    check("rst_err", err_unmapped, 0);
    out_d_valid = 1'b0;

    // four continuous Gets: 0,1,2,3,0
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("rr_ready", in_a_ready, 64'(1 << (k % 4)));
      check("rr_source", out_a_source, 64'(((k % 4) << 4) | (8 + k % 4)));
      step();
    end
    in_a_valid = '0;

    // 8-beat PutFull from input 1 while input 2 waits
    set_a(1, 3'd0, 4'd6, 4'h1, 33'h1000);
    set_a(2, 3'd4, 4'd3, 4'h2, 33'h2000);
    in_a_valid = 4'b0110;
    for (int b = 0; b < 8; b++) begin
      #1;
      check("burst_ready", in_a_ready, 4'b0010);
      step();
    end
    #1;
    check("after_burst_ready", in_a_ready, 4'b0100);
    check("after_burst_src", out_a_source, 6'h22);
    step();
    in_a_valid = '0;

    // reset in the middle of another 8-beat Put
    in_a_valid = 4'b0010;
    for (int b = 0; b < 4; b++) begin
      #1;
      check("burst2_ready", in_a_ready, 4'b0010);
      step();
    end
    reset = 1'b0;
    set_a(0, 3'd4, 4'd3, 4'h7, 33'h0ABC);
    set_a(3, 3'd4, 4'd3, 4'h3, 33'h3000);
    in_a_valid = 4'b1011;
    #1;
    check("mid_rst_valid", out_a_valid, 0);
    check("mid_rst_ready", in_a_ready, 0);
    step();
    reset = 1'b1;
    #1;
    check("post_rst_grant", in_a_ready, 4'b0001);
    check("post_rst_src", out_a_source, 6'h07);

    // stall input 0 for three cycles with input 3 waiting
    in_a_valid = 4'b1001;
    out_a_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("stall_valid", out_a_valid, 1);
      check("stall_src", out_a_source, 6'h07);
      check("stall_addr", out_a_address, 33'h0ABC);
      check("stall_ready", in_a_ready, 0);
      step();
    end
    out_a_ready = 1'b1;
    #1;
    check("unstall_ready", in_a_ready, 4'b0001);
    step();
    check("next_grant", in_a_ready, 4'b1000);
    check("next_src", out_a_source, 6'h33);
    step();
    in_a_valid = '0;

    // D routing by source prefix
    out_d_valid = 1'b1; out_d_source = 6'h25; in_d_ready = 4'b0000;
    out_d_data = 64'hDEAD_BEEF;
    #1;
    check("d_valid_route", in_d_valid, 4'b0100);
    check("d_source", in_d_source, 4'h5);
    check("d_data", in_d_data, 64'hDEAD_BEEF);
    check("d_ready_low", out_d_ready, 0);
    in_d_ready = 4'b0100;
    #1;
    check("d_ready_high", out_d_ready, 1);
    in_d_ready = 4'b1011;
    #1;
    check("d_ready_other", out_d_ready, 0);
    out_d_source = 6'h31; in_d_ready = 4'b1000;
    #1;
    check("d_valid_route3", in_d_valid, 4'b1000);
    check("d_ready3", out_d_ready, 1);
    step();
    out_d_valid = 1'b0;

    // unmapped response on the three-input instance
    o3_d_valid = 1'b1; o3_d_source = 6'h31; d3_ready_in = 3'b000;
    #1;
    check("unmap_ready", o3_d_ready, 1);
    check("unmap_valid", d3_valid, 0);
    check("unmap_err_before", err3, 0);
    step();
    check("unmap_err_set", err3, 1);
    o3_d_valid = 1'b0;
    step();
    check("unmap_err_sticky", err3, 1);
    check("mapped_err_clear", err_unmapped, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
